// File: rtl/isa_post_capture.sv
// ISA I/O-write front end of the POST card: synchronises the asynchronous ISA bus,
// qualifies IOW# pulses and latches bytes written to PORT_ADDR into the clock domain.
module isa_post_capture #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter logic [15:0] PORT_ADDR   = 16'h0080,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_LOW     = 3
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] IsaAddr,
  input  logic [7:0]            IsaData,
  input  logic                  IsaIowN,
  input  logic                  IsaAen,
  output logic [7:0]            Current,
  output logic                  CodeStrobe,
  output logic [15:0]           WriteCount,
  output logic                  Glitch
);

  localparam logic [ADDR_WIDTH-1:0] PORT_MATCH = ADDR_WIDTH'(PORT_ADDR);
  localparam logic [7:0]            MIN_LOW_C  = (MIN_LOW > 255) ? 8'hFF : 8'(MIN_LOW);

  typedef enum logic [1:0] {
    WAIT_HIGH = 2'd0,
    IDLE      = 2'd1,
    LOW       = 2'd2,
    COMMIT    = 2'd3
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [SYNC_STAGES-1:0] iow_p;
  logic [SYNC_STAGES-1:0] aen_p;
  logic [SYNC_STAGES-1:0] vld_p;
  logic [ADDR_WIDTH-1:0]  addr_p [SYNC_STAGES];
  logic [7:0]             data_p [SYNC_STAGES];

  logic                   iow_sync;
  logic                   aen_sync;
  logic                   vld_sync;
  logic [ADDR_WIDTH-1:0]  addr_sync;
  logic [7:0]             data_sync;

  state_t                 state;
  state_t                 state_next;

  logic [7:0]             low_cnt;
  logic                   aen_seen;
  logic [ADDR_WIDTH-1:0]  addr_lat;
  logic [7:0]             data_lat;
  logic [7:0]             current;
  logic [15:0]            write_count;
  logic                   glitch;

  logic                   short_pulse;
  logic                   addr_hit;
  logic                   latch_first;
  logic                   latch_more;
  logic                   flag_glitch;
  logic                   commit_go;

  // Synchroniser stages; vld_p marks when the chain holds genuine post-reset samples.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      iow_p <= '1;
      aen_p <= '1;
      vld_p <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        addr_p[i] <= '0;
        data_p[i] <= '0;
      end
    end else begin
      iow_p     <= {iow_p[SYNC_STAGES-2:0], IsaIowN};
      aen_p     <= {aen_p[SYNC_STAGES-2:0], IsaAen};
      vld_p     <= {vld_p[SYNC_STAGES-2:0], 1'b1};
      addr_p[0] <= IsaAddr;
      data_p[0] <= IsaData;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        addr_p[i] <= addr_p[i-1];
        data_p[i] <= data_p[i-1];
      end
    end
  end

  assign iow_sync  = iow_p[SYNC_STAGES-1];
  assign aen_sync  = aen_p[SYNC_STAGES-1];
  assign vld_sync  = vld_p[SYNC_STAGES-1];
  assign addr_sync = addr_p[SYNC_STAGES-1];
  assign data_sync = data_p[SYNC_STAGES-1];

  assign short_pulse = (low_cnt < MIN_LOW_C);
  assign addr_hit    = (addr_lat == PORT_MATCH) && !aen_seen;

  // Write qualifier FSM: state register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= WAIT_HIGH;
    else       state <= state_next;
  end

  // The reset value of the IOW# synchroniser reads as "high", so WAIT_HIGH only
  // trusts a high level once real samples have flushed the chain; otherwise a write
  // already in progress at reset release would look like a fresh falling edge.
  always_comb begin
    state_next = state;
    unique case (state)
      WAIT_HIGH: if (vld_sync && iow_sync) state_next = IDLE;
      IDLE:      if (!iow_sync) state_next = LOW;
      LOW: begin
        if (iow_sync) begin
          if (!short_pulse && addr_hit) state_next = COMMIT;
          else                          state_next = IDLE;
        end
      end
      COMMIT:    state_next = IDLE;
      default:   state_next = WAIT_HIGH;
    endcase
  end

  always_comb begin
    CodeStrobe  = 1'b0;
    latch_first = 1'b0;
    latch_more  = 1'b0;
    flag_glitch = 1'b0;
    commit_go   = 1'b0;
    unique case (state)
      IDLE:   latch_first = !iow_sync;
      LOW: begin
        latch_more  = !iow_sync;
        flag_glitch = iow_sync && short_pulse;
        commit_go   = iow_sync && !short_pulse && addr_hit;
      end
      COMMIT: CodeStrobe = 1'b1;
      default: ;
    endcase
  end

  // Capture stage: Current and WriteCount load on the edge entering COMMIT so they
  // change in the same cycle that CodeStrobe is high.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      low_cnt     <= '0;
      aen_seen    <= 1'b0;
      current     <= '0;
      write_count <= '0;
      glitch      <= 1'b0;
    end else begin
      if (latch_first) begin
        low_cnt  <= 8'd1;
        aen_seen <= aen_sync;
      end else if (latch_more) begin
        low_cnt  <= sat_inc8(low_cnt);
        aen_seen <= aen_seen | aen_sync;
      end
      if (flag_glitch) glitch <= 1'b1;
      if (commit_go) begin
        current     <= data_lat;
        write_count <= sat_inc16(write_count);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (latch_first || latch_more) begin
      addr_lat <= addr_sync;
      data_lat <= data_sync;
    end
  end

  assign Current    = current;
  assign WriteCount = write_count;
  assign Glitch     = glitch;

endmodule

// File: tb/tb_isa_post_capture.sv
// Directed bench for isa_post_capture: expected captures are queued as writes are
// driven and checked against Current/WriteCount whenever CodeStrobe fires.
module tb_isa_post_capture;

  localparam int SYNC = 2;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] IsaAddr;
  logic [7:0]  IsaData;
  logic        IsaIowN;
  logic        IsaAen;
  logic [7:0]  Current;
  logic        CodeStrobe;
  logic [15:0] WriteCount;
  logic        Glitch;

  isa_post_capture #(
    .ADDR_WIDTH (16),
    .PORT_ADDR  (16'h0080),
    .SYNC_STAGES(SYNC),
    .MIN_LOW    (3)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .IsaAddr   (IsaAddr),
    .IsaData   (IsaData),
    .IsaIowN   (IsaIowN),
    .IsaAen    (IsaAen),
    .Current   (Current),
    .CodeStrobe(CodeStrobe),
    .WriteCount(WriteCount),
    .Glitch    (Glitch)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [7:0]  code;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          compared   = 0;
  int          mismatched = 0;
  logic [15:0] model_cnt  = 16'h0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_capture(input logic [7:0] code);
    model_cnt = (model_cnt == 16'hFFFF) ? model_cnt : model_cnt + 16'd1;
    sb.push_back('{code: code, cnt: model_cnt});
  endtask

  // Entered and left at posedge+1.
  task automatic isa_write(input logic [15:0] a, input logic [7:0] d, input logic aen,
                           input int low_n, input int high_n, input bit captured);
    if (captured) expect_capture(d);
    IsaAddr = a;
    IsaData = d;
    IsaAen  = aen;
    IsaIowN = 1'b0;
    repeat (low_n) @(posedge Clock);
    #1 IsaIowN = 1'b1;
    IsaAen = 1'b0;
    repeat (high_n) @(posedge Clock);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge Clock);
      #1;
      n++;
    end
    check({tag, "_drain"}, sb.size(), 0);
  endtask

  // Scoreboard: every strobe must match the oldest queued capture.
  always @(negedge Clock) begin
    exp_t e;
    if (!Reset && CodeStrobe) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("strobe_current", Current, e.code);
        check("strobe_count", WriteCount, e.cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset   = 1'b1;
    IsaAddr = 16'h0000;
    IsaData = 8'h00;
    IsaIowN = 1'b1;
    IsaAen  = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check("rst_current", Current, 8'h00);
    check("rst_strobe", CodeStrobe, 1'b0);
    check("rst_count", WriteCount, 16'h0000);
    check("rst_glitch", Glitch, 1'b0);
    Reset = 1'b0;
    repeat (4) @(posedge Clock);
    #1;

    // First valid write with explicit latency check.
    expect_capture(8'hA5);
    IsaAddr = 16'h0080;
    IsaData = 8'hA5;
    IsaAen  = 1'b0;
    IsaIowN = 1'b0;
    repeat (5) @(posedge Clock);
    #1 IsaIowN = 1'b1;
    repeat (SYNC) @(posedge Clock);
    #1;
    check("latency_early_strobe", CodeStrobe, 1'b0);
    @(posedge Clock);
    #1;
    check("latency_strobe", CodeStrobe, 1'b1);
    check("latency_current", Current, 8'hA5);
    repeat (4) @(posedge Clock);
    #1;
    wait_drain("first");
    check("first_count", WriteCount, 16'd1);

    // Wrong address and DMA cycle are ignored silently.
    isa_write(16'h0081, 8'h5A, 1'b0, 5, 6, 1'b0);
    isa_write(16'h0080, 8'h5A, 1'b1, 5, 6, 1'b0);
    check("reject_current", Current, 8'hA5);
    check("reject_count", WriteCount, 16'd1);
    check("reject_glitch", Glitch, 1'b0);

    // Short pulse sets the sticky glitch flag, then a valid write still captures.
    isa_write(16'h0080, 8'h11, 1'b0, 1, 5, 1'b0);
    check("glitch_set", Glitch, 1'b1);
    check("glitch_current", Current, 8'hA5);
    isa_write(16'h0080, 8'h22, 1'b0, 5, 6, 1'b1);
    wait_drain("post_glitch");
    check("post_glitch_current", Current, 8'h22);
    check("glitch_sticky", Glitch, 1'b1);

    // Reset during an IOW# low phase; the in-flight write must not be captured.
    IsaAddr = 16'h0080;
    IsaData = 8'h77;
    IsaIowN = 1'b0;
    #2 Reset = 1'b1;
    #1;
    check("async_rst_current", Current, 8'h00);
    check("async_rst_count", WriteCount, 16'h0000);
    check("async_rst_glitch", Glitch, 1'b0);
    model_cnt = 16'h0000;
    sb.delete();
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b0;
    repeat (4) @(posedge Clock);
    #1 IsaIowN = 1'b1;
    repeat (6) @(posedge Clock);
    #1;
    check("rst_inflight_current", Current, 8'h00);
    check("rst_inflight_count", WriteCount, 16'h0000);
    isa_write(16'h0080, 8'h3C, 1'b0, 5, 6, 1'b1);
    wait_drain("after_rst");
    check("after_rst_current", Current, 8'h3C);

    // Back-to-back writes with one-clock high gaps, including a duplicate value.
    isa_write(16'h0080, 8'h01, 1'b0, 5, 1, 1'b1);
    isa_write(16'h0080, 8'h01, 1'b0, 5, 1, 1'b1);
    isa_write(16'h0080, 8'h02, 1'b0, 5, 6, 1'b1);
    wait_drain("b2b");
    check("b2b_current", Current, 8'h02);
    check("b2b_count", WriteCount, model_cnt);

    // Saturation: preload the counter near its limit.
    force dut.write_count = 16'hFFFE;
    @(posedge Clock);
    #1;
    release dut.write_count;
    @(posedge Clock);
    #1;
    model_cnt = 16'hFFFE;
    check("preload_count", WriteCount, 16'hFFFE);
    isa_write(16'h0080, 8'hE1, 1'b0, 5, 6, 1'b1);
    isa_write(16'h0080, 8'hE2, 1'b0, 5, 6, 1'b1);
    wait_drain("sat");
    check("sat_count", WriteCount, 16'hFFFF);
    check("sat_current", Current, 8'hE2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
